prim_up_counter: RTL and testbench
==================================

Name: prim_up_counter

Overview:
Programmable up-counting event counter/timer. It is the count-up counterpart to the team's loadable down counter.
- Counts i_en ticks from 0 toward a runtime limit.
- Supports three end-of-count modes: wrap, one-shot and saturate.
- Provides a registered wrap pulse, a sticky overflow flag and a small run-control FSM.
- Used for timer peripherals, baud/tick generators and event statistics in the milestone SoC.

Parameters:
WIDTH, 32, counter/limit/load width in bits (>=2)
RESET_VAL, all-zeros (WIDTH bits), value of o_count after reset and i_clr

Ports:
i_clk  input  1  clock, rising edge
i_rstn  input  1  reset, synchronous, active-low
i_start  input  1  arm/restart: count<=0, enter RUN
i_stop  input  1  leave RUN/DONE to IDLE, count held
i_clr  input  1  synchronous clear: count<=RESET_VAL, state IDLE
i_en  input  1  count tick (only effective in RUN)
i_load  input  1  synchronous load of i_load_data, state unchanged
i_load_data  input  WIDTH  load value
i_limit  input  WIDTH  terminal count (inclusive)
i_mode  input  2  end-of-count mode, cnt_mode_e
i_ovf_clr  input  1  clear sticky o_ovf
o_count  output  WIDTH  current count (registered)
o_wrap  output  1  registered 1-cycle terminal-count pulse
o_ovf  output  1  sticky overflow flag
o_busy  output  1  state==RUN
o_done  output  1  state==DONE

Behaviour:
Reset
- Sampled only on the rising edge of i_clk while i_rstn==0.
- All outputs are registered. Reset values: o_count=RESET_VAL, o_wrap=0, o_ovf=0, o_busy=0, o_done=0, state=IDLE.
- Reset asserted mid-run aborts immediately at that edge.

States
- IDLE (counting disabled), RUN, DONE (one-shot finished, count frozen).
- o_busy and o_done are decoded from registered state; no combinational outputs.

Per-edge priority (highest first)
1. !i_rstn
2. i_clr: count<=RESET_VAL; state<=IDLE; o_ovf unaffected.
3. i_stop: state<=IDLE; count held.
4. i_load: count<=i_load_data; state unchanged; a simultaneous i_en is ignored.
5. i_start: count<=0; state<=RUN. Legal in any state; restarts when already in RUN.
6. i_en while in RUN: terminal-count step, below.
- i_en outside RUN: no effect.

Terminal test
- term = (o_count >= i_limit), unsigned.
- A count above the limit (after a load, or after i_limit is lowered) is treated as terminal.

i_en in RUN, by mode
- term==0: count<=count+1, modulo 2^WIDTH.
- term==1, MODE_WRAP: count<=0; o_wrap=1 next cycle; o_ovf<=1; stay in RUN.
- term==1, MODE_ONESHOT: count held; o_wrap=1 next cycle; state<=DONE.
- term==1, MODE_SAT: count held; o_ovf<=1; o_wrap stays 0; stay in RUN.
- i_mode==2'b11 (reserved): behaves as MODE_WRAP.

Flags and live inputs
- i_limit and i_mode are sampled live each edge; there is no shadow register.
- i_limit==0 in MODE_WRAP: o_wrap pulses on every i_en.
- o_wrap is high for exactly the one cycle following the terminal edge. Otherwise it is 0, including on edges where i_clr, i_stop or i_load win.
- o_ovf is sticky. i_ovf_clr clears it. If set and clear occur on the same edge, set wins.
- Adder is WIDTH bits; the carry-out is discarded. With i_limit=all-ones, the limit is reached before any carry can occur.

Decomposition:
- Package prim_counter_pkg:
  - typedef enum logic [1:0] cnt_mode_e {MODE_WRAP=2'b00, MODE_ONESHOT=2'b01, MODE_SAT=2'b10}
  - typedef enum logic [1:0] cnt_state_e {ST_IDLE, ST_RUN, ST_DONE}
- Sub-module: instantiate the existing prim_mux_2x1 to select between the next increment/terminal value and i_load_data.
- FSM, flags and compare stay inline.

Test Plan:
- Reset: drive i_rstn=0 with no clock edge -> outputs unchanged. After one edge -> o_count=0, all flags 0. Assert reset mid-count at 5 -> next edge o_count=0, IDLE.
- Wrap: WIDTH=8, i_limit=3, MODE_WRAP, i_start, then continuous i_en -> o_count 0,1,2,3,0,1. o_wrap high only in the cycle o_count returns to 0. o_ovf=1 from then on. i_ovf_clr -> o_ovf=0.
- One-shot: i_limit=2, MODE_ONESHOT, i_start, 5 ticks -> count 0,1,2 then holds at 2. o_wrap single pulse; o_done=1, o_busy=0. Further i_en -> no change. i_start -> count 0, o_busy=1.
- Saturate: i_limit=8'hFF, MODE_SAT, load 8'hFE, 3 ticks -> FF, FF, FF. o_ovf=1, o_wrap never asserts.
- Priority: same edge i_clr+i_load+i_en -> count=RESET_VAL, IDLE. Same edge i_load=9 + i_en -> count=9. Same edge i_ovf_clr + wrap -> o_ovf stays 1.
- Limit change: count at 10, then i_limit set to 4 in MODE_WRAP with i_en -> count 0, o_wrap pulse (>= compare).

Source files
------------

// File: rtl/prim_counter_pkg.sv
// rtl/prim_counter_pkg.sv - shared types for the up counter
package prim_counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_ONESHOT = 2'b01,
    MODE_SAT     = 2'b10
  } cnt_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } cnt_state_e;

endpackage

// File: rtl/prim_up_counter_if.sv
// rtl/prim_up_counter_if.sv - control/status bundle of the up counter
interface prim_up_counter_if #(
  parameter int WIDTH = 32
);
  logic             i_start;
  logic             i_stop;
  logic             i_clr;
  logic             i_en;
  logic             i_load;
  logic [WIDTH-1:0] i_load_data;
  logic [WIDTH-1:0] i_limit;
  logic [1:0]       i_mode;
  logic             i_ovf_clr;
  logic [WIDTH-1:0] o_count;
  logic             o_wrap;
  logic             o_ovf;
  logic             o_busy;
  logic             o_done;

  modport master (
    output i_start, i_stop, i_clr, i_en, i_load, i_load_data, i_limit, i_mode, i_ovf_clr,
    input  o_count, o_wrap, o_ovf, o_busy, o_done
  );

  modport slave (
    input  i_start, i_stop, i_clr, i_en, i_load, i_load_data, i_limit, i_mode, i_ovf_clr,
    output o_count, o_wrap, o_ovf, o_busy, o_done
  );
endinterface

// File: rtl/prim_mux_2x1.sv
// rtl/prim_mux_2x1.sv - two-input word multiplexer
module prim_mux_2x1 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sel,
  output logic [WIDTH-1:0] o_y
);
  assign o_y = i_sel ? i_b : i_a;
endmodule

// File: rtl/prim_up_counter.sv
// rtl/prim_up_counter.sv - programmable up counter with wrap/one-shot/saturate modes
module prim_up_counter
  import prim_counter_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic               i_clk,
  input logic               i_rstn,
  prim_up_counter_if.slave  bus
);

  cnt_state_e       state;
  logic [WIDTH-1:0] count;
  logic             wrap_q;
  logic             ovf_q;
  logic             term;
  logic             mode_wrap;
  logic             mode_oneshot;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] next_val;
  logic             step_fire;
  logic             ovf_set;

  // A count above the limit is terminal too, so lowering i_limit never strands the counter.
  assign term         = (count >= bus.i_limit);
  assign mode_oneshot = (bus.i_mode == MODE_ONESHOT);
  assign mode_wrap    = !mode_oneshot && (bus.i_mode != MODE_SAT);

  always_comb begin
    step_val = count + 1'b1;
    if (term) begin
      step_val = mode_wrap ? '0 : count;
    end
  end

  prim_mux_2x1 #(.WIDTH(WIDTH)) u_next_mux (
    .i_a   (step_val),
    .i_b   (bus.i_load_data),
    .i_sel (bus.i_load),
    .o_y   (next_val)
  );

  assign step_fire = !bus.i_clr && !bus.i_stop && !bus.i_load && !bus.i_start
                     && bus.i_en && (state == ST_RUN);
  assign ovf_set   = step_fire && term && !mode_oneshot;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state  <= ST_IDLE;
      count  <= RESET_VAL;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (bus.i_clr) begin
        count <= RESET_VAL;
        state <= ST_IDLE;
      end else if (bus.i_stop) begin
        state <= ST_IDLE;
      end else if (bus.i_load) begin
        count <= next_val;
      end else if (bus.i_start) begin
        count <= '0;
        state <= ST_RUN;
      end else if (step_fire) begin
        count <= next_val;
        if (term && mode_oneshot) begin
          wrap_q <= 1'b1;
          state  <= ST_DONE;
        end else if (term && mode_wrap) begin
          wrap_q <= 1'b1;
        end
      end
      // Set beats clear so a same-edge overflow is never lost.
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (bus.i_ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign bus.o_count = count;
  assign bus.o_wrap  = wrap_q;
  assign bus.o_ovf   = ovf_q;
  assign bus.o_busy  = (state == ST_RUN);
  assign bus.o_done  = (state == ST_DONE);

endmodule

// File: tb/tb_prim_up_counter.sv
// tb/tb_prim_up_counter.sv - table-driven scoreboard bench for prim_up_counter
module tb_prim_up_counter;

  localparam int W = 8;

  typedef struct {
    logic         rstn, start, stop, clr, en, load;
    logic [W-1:0] ld, lim;
    logic [1:0]   mode;
    logic         oc;
    logic [W-1:0] c;
    logic         w, o, b, d;
  } vec_t;

  typedef struct {
    logic [W-1:0] c;
    logic         w, o, b, d;
    int           idx;
  } exp_t;

  logic i_clk = 1'b0;
  logic i_rstn;
  int   errors = 0;
  int   checks = 0;

  vec_t tbl[$];
  exp_t sb[$];

  prim_up_counter_if #(.WIDTH(W)) bus ();

  prim_up_counter #(.WIDTH(W), .RESET_VAL('0)) dut (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .bus    (bus)
  );

  always #5 i_clk = ~i_clk;

  function automatic vec_t v(logic rstn, logic start, logic stop, logic clr, logic en, logic load,
                             logic [W-1:0] ld, logic [W-1:0] lim, logic [1:0] mode, logic oc,
                             logic [W-1:0] c, logic w, logic o, logic b, logic d);
    vec_t r;
    r.rstn = rstn; r.start = start; r.stop = stop; r.clr = clr; r.en = en; r.load = load;
    r.ld = ld; r.lim = lim; r.mode = mode; r.oc = oc;
    r.c = c; r.w = w; r.o = o; r.b = b; r.d = d;
    return r;
  endfunction

  task automatic drive(vec_t x);
    i_rstn          = x.rstn;
    bus.i_start     = x.start;
    bus.i_stop      = x.stop;
    bus.i_clr       = x.clr;
    bus.i_en        = x.en;
    bus.i_load      = x.load;
    bus.i_load_data = x.ld;
    bus.i_limit     = x.lim;
    bus.i_mode      = x.mode;
    bus.i_ovf_clr   = x.oc;
  endtask

  task automatic check_out(exp_t e, string name);
    checks++;
    if (bus.o_count !== e.c || bus.o_wrap !== e.w || bus.o_ovf !== e.o ||
        bus.o_busy !== e.b || bus.o_done !== e.d) begin
      errors++;
      $display("FAIL %s%0d: got count=%0h wrap=%b ovf=%b busy=%b done=%b, want count=%0h wrap=%b ovf=%b busy=%b done=%b",
               name, e.idx, bus.o_count, bus.o_wrap, bus.o_ovf, bus.o_busy, bus.o_done,
               e.c, e.w, e.o, e.b, e.d);
    end
  endtask

  task automatic apply(vec_t x, int idx);
    exp_t e;
    @(negedge i_clk);
    drive(x);
    e.c = x.c; e.w = x.w; e.o = x.o; e.b = x.b; e.d = x.d; e.idx = idx;
    sb.push_back(e);
    @(posedge i_clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_empty: got 0 entries, want 1");
    end else begin
      check_out(sb.pop_front(), "vec");
    end
  endtask

  initial begin
    exp_t e;
    // rstn start stop clr en load ld lim mode oc | count wrap ovf busy done
    tbl.push_back(v(0,0,0,0,0,0,8'h00,8'd3,2'd0,0, 8'd0,0,0,0,0));
    // wrap mode, limit 3
    tbl.push_back(v(1,1,0,0,0,0,8'h00,8'd3,2'd0,0, 8'd0,0,0,1,0));
    tbl.push_back(v(1,0,0,0,1,0,8'h00,8'd3,2'd0,0, 8'd1,0,0,1,0));
    tbl.push_back(v(1,0,0,0,1,0,8'h00,8'd3,2'd0,0, 8'd2,0,0,1,0));
    tbl.push_back(v(1,0,0,0,1,0,8'h00,8'd3,2'd0,0, 8'd3,0,0,1,0));
    tbl.push_back(v(1,0,0,0,1,0,8'h00,8'd3,2'd0,0, 8'd0,1,1,1,0));
    tbl.push_back(v(1,0,0,0,1,0,8'h00,8'd3,2'd0,0, 8'd1,0,1,1,0));
    tbl.push_back(v(1,0,0,0,1,0,8'h00,8'd3,2'd0,1, 8'd2,0,0,1,0));
    tbl.push_back(v(1,0,0,0,1,0,8'h00,8'd3,2'd0,0, 8'd3,0,0,1,0));
    tbl.push_back(v(1,0,0,0,1,0,8'h00,8'd3,2'd0,1, 8'd0,1,1,1,0));
    tbl.push_back(v(1,0,1,0,0,0,8'h00,8'd3,2'd0,0, 8'd0,0,1,0,0));
    tbl.push_back(v(1,0,0,0,1,0,8'h00,8'd3,2'd0,0, 8'd0,0,1,0,0));
    tbl.push_back(v(1,0,0,0,0,0,8'h00,8'd3,2'd0,1, 8'd0,0,0,0,0));
    // one-shot, limit 2
    tbl.push_back(v(1,1,0,0,0,0,8'h00,8'd2,2'd1,0, 8'd0,0,0,1,0));
    tbl.push_back(v(1,0,0,0,1,0,8'h00,8'd2,2'd1,0, 8'd1,0,0,1,0));
    tbl.push_back(v(1,0,0,0,1,0,8'h00,8'd2,2'd1,0, 8'd2,0,0,1,0));
    tbl.push_back(v(1,0,0,0,1,0,8'h00,8'd2,2'd1,0, 8'd2,1,0,0,1));
    tbl.push_back(v(1,0,0,0,1,0,8'h00,8'd2,2'd1,0, 8'd2,0,0,0,1));
    tbl.push_back(v(1,0,0,0,1,0,8'h00,8'd2,2'd1,0, 8'd2,0,0,0,1));
    tbl.push_back(v(1,1,0,0,0,0,8'h00,8'd2,2'd1,0, 8'd0,0,0,1,0));
    // saturate at all-ones
    tbl.push_back(v(1,0,0,0,0,1,8'hFE,8'hFF,2'd2,0, 8'hFE,0,0,1,0));
    tbl.push_back(v(1,0,0,0,1,0,8'h00,8'hFF,2'd2,0, 8'hFF,0,0,1,0));
    tbl.push_back(v(1,0,0,0,1,0,8'h00,8'hFF,2'd2,0, 8'hFF,0,1,1,0));
    tbl.push_back(v(1,0,0,0,1,0,8'h00,8'hFF,2'd2,0, 8'hFF,0,1,1,0));
    tbl.push_back(v(1,0,0,0,1,0,8'h00,8'hFF,2'd2,0, 8'hFF,0,1,1,0));
    // priority
    tbl.push_back(v(1,0,0,1,1,1,8'h07,8'hFF,2'd0,0, 8'd0,0,1,0,0));
    tbl.push_back(v(1,1,0,0,0,0,8'h00,8'hFF,2'd0,0, 8'd0,0,1,1,0));
    tbl.push_back(v(1,0,0,0,1,1,8'h09,8'hFF,2'd0,0, 8'd9,0,1,1,0));
    tbl.push_back(v(1,0,0,0,1,0,8'h00,8'd10,2'd0,0, 8'd10,0,1,1,0));
    // limit lowered below count
    tbl.push_back(v(1,0,0,0,1,0,8'h00,8'd4,2'd0,0, 8'd0,1,1,1,0));
    tbl.push_back(v(1,0,0,0,1,0,8'h00,8'd4,2'd0,0, 8'd1,0,1,1,0));
    // limit 0 wraps on every tick
    tbl.push_back(v(1,0,0,0,1,0,8'h00,8'd0,2'd0,0, 8'd0,1,1,1,0));
    tbl.push_back(v(1,0,0,0,1,0,8'h00,8'd0,2'd0,0, 8'd0,1,1,1,0));
    tbl.push_back(v(1,0,0,0,0,0,8'h00,8'd0,2'd0,0, 8'd0,0,1,1,0));
    // reserved mode acts as wrap
    tbl.push_back(v(1,0,0,0,1,0,8'h00,8'd1,2'd3,0, 8'd1,0,1,1,0));
    tbl.push_back(v(1,0,0,0,1,0,8'h00,8'd1,2'd3,0, 8'd0,1,1,1,0));
    // stop over load, load over start
    tbl.push_back(v(1,0,1,0,0,1,8'h05,8'd1,2'd0,0, 8'd0,0,1,0,0));
    tbl.push_back(v(1,0,0,0,0,1,8'h05,8'd1,2'd0,0, 8'd5,0,1,0,0));
    tbl.push_back(v(1,1,0,0,0,1,8'h06,8'd1,2'd0,0, 8'd6,0,1,0,0));
    tbl.push_back(v(1,1,0,0,0,0,8'h00,8'd1,2'd0,0, 8'd0,0,1,1,0));
    // all-ones limit reached before the adder carries
    tbl.push_back(v(1,0,0,0,0,1,8'hFD,8'hFF,2'd0,0, 8'hFD,0,1,1,0));
    tbl.push_back(v(1,0,0,0,1,0,8'h00,8'hFF,2'd0,0, 8'hFE,0,1,1,0));
    tbl.push_back(v(1,0,0,0,1,0,8'h00,8'hFF,2'd0,0, 8'hFF,0,1,1,0));
    tbl.push_back(v(1,0,0,0,1,0,8'h00,8'hFF,2'd0,0, 8'h00,1,1,1,0));
    // count to 5 ahead of the mid-run reset
    for (int k = 1; k <= 5; k++) begin
      tbl.push_back(v(1,0,0,0,1,0,8'h00,8'd20,2'd0,0, W'(k),0,1,1,0));
    end

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], i);
    end

    // Reset asserted without an edge must not disturb outputs.
    @(negedge i_clk);
    i_rstn = 1'b0;
    #1;
    e.c = 8'd5; e.w = 0; e.o = 1; e.b = 1; e.d = 0; e.idx = 0;
    check_out(e, "reset_no_edge");
    e.c = 8'd0; e.w = 0; e.o = 0; e.b = 0; e.d = 0; e.idx = 1;
    sb.push_back(e);
    @(posedge i_clk);
    #1;
    check_out(sb.pop_front(), "reset_mid_run");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
